// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the decode->execute hazard controller: state encoding
// and the operand-forwarding match helper.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam int REG_W = 5;

  // x0 is hardwired to zero, so a write to it must never be forwarded.
  function automatic logic fwd_match(input logic             valid,
                                     input logic             reg_write,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs);
    return valid & reg_write & (rd != '0) & (rd == rs);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline is the master
// (drives execute/decode status and the memory ack); the controller is the slave.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipe_hazard_ctrl_pkg::*;

  logic             ex_valid;
  logic             ex_load;
  logic             ex_store;
  logic             ex_reg_write;
  logic [REG_W-1:0] ex_rd;
  logic             ex_branch_taken;
  logic             ex_next_sel;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             dmem_ack;

  logic             pc_en;
  logic             pipe_en;
  logic             pipe_flush;
  logic             dmem_req;
  logic             fwd_a;
  logic             fwd_b;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ex_valid, ex_load, ex_store, ex_reg_write, ex_rd,
           ex_branch_taken, ex_next_sel, id_rs1, id_rs2, dmem_ack,
    input  pc_en, pipe_en, pipe_flush, dmem_req, fwd_a, fwd_b,
           mem_timeout, stall_cnt
  );

  modport slave (
    input  ex_valid, ex_load, ex_store, ex_reg_write, ex_rd,
           ex_branch_taken, ex_next_sel, id_rs1, id_rs2, dmem_ack,
    output pc_en, pipe_en, pipe_flush, dmem_req, fwd_a, fwd_b,
           mem_timeout, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_wait_timer.sv
// Loadable up/down counter with a terminal-value flag; used both for the
// dmem wait count and for the branch-penalty countdown.
module pipe_hazard_ctrl_wait_timer #(
  parameter int           W        = 4,
  parameter bit           COUNT_UP = 1'b1,
  parameter logic [W-1:0] TERM     = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         term
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en) begin
      cnt_reg <= COUNT_UP ? cnt_reg + 1'b1 : cnt_reg - 1'b1;
    end
  end

  assign term = (cnt_reg == TERM);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode->execute sequencing controller: stalls on outstanding dmem accesses,
// inserts bubbles after redirects, forwards execute results, tracks stalls.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT       = 16,
  parameter int BRANCH_PENALTY = 1,
  parameter int CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int              WAIT_W   = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_TERM = WAIT_W'(MAX_WAIT - 1);
  localparam logic [2:0]      PEN_LOAD = 3'(BRANCH_PENALTY - 1);

  state_t           state_reg, state_next;
  logic             mem_timeout_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic mem, redirect;
  logic wait_term, pen_term;
  logic en_c, flush_c, req_c;

  assign mem      = bus.ex_valid & (bus.ex_load | bus.ex_store);
  assign redirect = bus.ex_valid & (bus.ex_branch_taken | bus.ex_next_sel);

  // Restarts from zero whenever not waiting, so each access gets a full budget.
  pipe_hazard_ctrl_wait_timer #(
    .W        (WAIT_W),
    .COUNT_UP (1'b1),
    .TERM     (WAIT_TERM)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .load     ((state_reg != ST_WAIT) | bus.dmem_ack),
    .load_val ('0),
    .en       (state_reg == ST_WAIT),
    .term     (wait_term)
  );

  pipe_hazard_ctrl_wait_timer #(
    .W        (3),
    .COUNT_UP (1'b0),
    .TERM     (3'd1)
  ) u_pen_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state_reg == ST_RUN),
    .load_val (PEN_LOAD),
    .en       (state_reg == ST_FLUSH),
    .term     (pen_term)
  );

  always_comb begin
    state_next = state_reg;
    en_c       = 1'b0;
    flush_c    = 1'b0;
    req_c      = 1'b0;
    case (state_reg)
      ST_RUN: begin
        req_c = mem;
        // A memory op takes priority over a redirect on the same instruction.
        if (mem) begin
          if (bus.dmem_ack) begin
            en_c = 1'b1;
          end else begin
            state_next = ST_WAIT;
          end
        end else if (redirect) begin
          en_c    = 1'b1;
          flush_c = 1'b1;
          if (BRANCH_PENALTY > 1) begin
            state_next = ST_FLUSH;
          end
        end else begin
          en_c = 1'b1;
        end
      end
      ST_WAIT: begin
        req_c = 1'b1;
        if (bus.dmem_ack) begin
          en_c       = 1'b1;
          state_next = ST_RUN;
        end else if (wait_term) begin
          state_next = ST_ERR;
        end
      end
      ST_FLUSH: begin
        en_c    = 1'b1;
        flush_c = 1'b1;
        if (pen_term) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_ERR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_RUN;
      mem_timeout_reg <= 1'b0;
      stall_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next == ST_ERR) begin
        mem_timeout_reg <= 1'b1;
      end
      if (!en_c && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end
  end

  // Outputs are forced to their safe values asynchronously while reset is low.
  assign bus.pc_en       = rst & en_c;
  assign bus.pipe_en     = rst & en_c;
  assign bus.pipe_flush  = ~rst | flush_c;
  assign bus.dmem_req    = rst & req_c;
  assign bus.fwd_a       = rst & fwd_match(bus.ex_valid, bus.ex_reg_write, bus.ex_rd, bus.id_rs1);
  assign bus.fwd_b       = rst & fwd_match(bus.ex_valid, bus.ex_reg_write, bus.ex_rd, bus.id_rs2);
  assign bus.mem_timeout = mem_timeout_reg;
  assign bus.stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MAX_WAIT=4, BRANCH_PENALTY=2.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();

  pipe_hazard_ctrl #(
    .MAX_WAIT       (4),
    .BRANCH_PENALTY (2),
    .CNT_W          (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("vec %0d %s obs=%0d exp=%0d", vectors, tag, obs, exp);
  endtask

  task automatic idle();
    bus.ex_valid        = 1'b0;
    bus.ex_load         = 1'b0;
    bus.ex_store        = 1'b0;
    bus.ex_reg_write    = 1'b0;
    bus.ex_rd           = 5'd0;
    bus.ex_branch_taken = 1'b0;
    bus.ex_next_sel     = 1'b0;
    bus.id_rs1          = 5'd0;
    bus.id_rs2          = 5'd0;
    bus.dmem_ack        = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset
    rst = 1'b0;
    idle();
    bus.ex_valid = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
    repeat (3) begin
      cyc(); #1;
      chk("rst_pc_en", bus.pc_en, 1'b0);
    end
    chk("rst_pipe_en", bus.pipe_en, 1'b0);
    chk("rst_flush", bus.pipe_flush, 1'b1);
    chk("rst_dmem_req", bus.dmem_req, 1'b0);
    chk("rst_fwd_a", bus.fwd_a, 1'b0);
    chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
    chk("rst_timeout", bus.mem_timeout, 1'b0);
    idle();
    cyc(); rst = 1'b1; #1;
    chk("rel_pc_en", bus.pc_en, 1'b1);
    chk("rel_pipe_en", bus.pipe_en, 1'b1);
    chk("rel_flush", bus.pipe_flush, 1'b0);

    // 2. load acked after 3 stalled cycles
    cyc(); bus.ex_valid = 1'b1; bus.ex_load = 1'b1; #1;
    chk("ld_issue_pc_en", bus.pc_en, 1'b0);
    chk("ld_issue_pipe_en", bus.pipe_en, 1'b0);
    chk("ld_issue_req", bus.dmem_req, 1'b1);
    repeat (2) begin
      cyc(); #1;
      chk("ld_wait_pc_en", bus.pc_en, 1'b0);
      chk("ld_wait_req", bus.dmem_req, 1'b1);
    end
    cyc(); bus.dmem_ack = 1'b1; #1;
    chk("ld_ack_pc_en", bus.pc_en, 1'b1);
    chk("ld_ack_pipe_en", bus.pipe_en, 1'b1);
    chk("ld_ack_req", bus.dmem_req, 1'b1);
    chk("ld_ack_stall_cnt", bus.stall_cnt, 32'd3);
    cyc(); idle(); #1;
    chk("ld_after_pc_en", bus.pc_en, 1'b1);
    chk("ld_after_req", bus.dmem_req, 1'b0);
    chk("ld_after_stall_cnt", bus.stall_cnt, 32'd3);

    // zero-wait access with a simultaneous branch: memory wins, no flush
    cyc(); bus.ex_valid = 1'b1; bus.ex_load = 1'b1; bus.dmem_ack = 1'b1; bus.ex_branch_taken = 1'b1; #1;
    chk("zw_pc_en", bus.pc_en, 1'b1);
    chk("zw_req", bus.dmem_req, 1'b1);
    chk("zw_flush", bus.pipe_flush, 1'b0);
    cyc(); idle(); #1;
    chk("zw_next_flush", bus.pipe_flush, 1'b0);
    chk("zw_next_stall_cnt", bus.stall_cnt, 32'd3);

    // 3. taken branch: two bubble cycles
    cyc(); bus.ex_valid = 1'b1; bus.ex_branch_taken = 1'b1; #1;
    chk("br_c0_flush", bus.pipe_flush, 1'b1);
    chk("br_c0_pc_en", bus.pc_en, 1'b1);
    chk("br_c0_pipe_en", bus.pipe_en, 1'b1);
    cyc(); idle(); #1;
    chk("br_c1_flush", bus.pipe_flush, 1'b1);
    chk("br_c1_pc_en", bus.pc_en, 1'b1);
    cyc(); #1;
    chk("br_c2_flush", bus.pipe_flush, 1'b0);
    chk("br_c2_pc_en", bus.pc_en, 1'b1);
    // jump redirect
    cyc(); bus.ex_valid = 1'b1; bus.ex_next_sel = 1'b1; #1;
    chk("jmp_c0_flush", bus.pipe_flush, 1'b1);
    cyc(); idle(); #1;
    chk("jmp_c1_flush", bus.pipe_flush, 1'b1);
    cyc(); #1;
    chk("jmp_c2_flush", bus.pipe_flush, 1'b0);
    // redirect from a bubble is ignored
    cyc(); bus.ex_branch_taken = 1'b1; #1;
    chk("bubble_br_flush", bus.pipe_flush, 1'b0);
    cyc(); idle(); #1;
    chk("bubble_br_next_flush", bus.pipe_flush, 1'b0);

    // 4. forwarding
    cyc(); bus.ex_valid = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_rs2 = 5'd6; #1;
    chk("fwd_rs1_a", bus.fwd_a, 1'b1);
    chk("fwd_rs1_b", bus.fwd_b, 1'b0);
    bus.id_rs1 = 5'd6; bus.id_rs2 = 5'd5; #1;
    chk("fwd_rs2_a", bus.fwd_a, 1'b0);
    chk("fwd_rs2_b", bus.fwd_b, 1'b1);
    bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; #1;
    chk("fwd_x0_a", bus.fwd_a, 1'b0);
    chk("fwd_x0_b", bus.fwd_b, 1'b0);
    bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_rs2 = 5'd5; bus.ex_valid = 1'b0; #1;
    chk("fwd_inval_a", bus.fwd_a, 1'b0);
    chk("fwd_inval_b", bus.fwd_b, 1'b0);
    bus.ex_valid = 1'b1; bus.ex_reg_write = 1'b0; #1;
    chk("fwd_nowr_a", bus.fwd_a, 1'b0);
    chk("fwd_nowr_pc_en", bus.pc_en, 1'b1);
    idle();

    // 6. reset during WAIT, then a fresh access uses the full wait budget
    cyc(); bus.ex_valid = 1'b1; bus.ex_store = 1'b1; #1;
    chk("rw_issue_req", bus.dmem_req, 1'b1);
    repeat (2) begin
      cyc(); #1;
      chk("rw_wait_req", bus.dmem_req, 1'b1);
    end
    rst = 1'b0; #1;
    chk("rw_rst_req", bus.dmem_req, 1'b0);
    chk("rw_rst_pc_en", bus.pc_en, 1'b0);
    chk("rw_rst_flush", bus.pipe_flush, 1'b1);
    cyc(); rst = 1'b1; #1;
    chk("rw_rel_pc_en", bus.pc_en, 1'b0);
    chk("rw_rel_req", bus.dmem_req, 1'b1);
    chk("rw_rel_stall_cnt", bus.stall_cnt, 32'd0);
    repeat (3) begin
      cyc(); #1;
      chk("rw_wait2_pc_en", bus.pc_en, 1'b0);
    end
    cyc(); bus.dmem_ack = 1'b1; #1;
    chk("rw_lastack_pc_en", bus.pc_en, 1'b1);
    chk("rw_lastack_timeout", bus.mem_timeout, 1'b0);
    chk("rw_lastack_stall_cnt", bus.stall_cnt, 32'd4);
    cyc(); idle(); #1;
    chk("rw_after_timeout", bus.mem_timeout, 1'b0);
    chk("rw_after_pc_en", bus.pc_en, 1'b1);

    // 5. timeout on a store that is never acked
    cyc(); bus.ex_valid = 1'b1; bus.ex_store = 1'b1; #1;
    chk("to_issue_pc_en", bus.pc_en, 1'b0);
    repeat (4) begin
      cyc(); #1;
      chk("to_wait_timeout", bus.mem_timeout, 1'b0);
      chk("to_wait_req", bus.dmem_req, 1'b1);
    end
    cyc(); bus.dmem_ack = 1'b1; #1;
    chk("to_err_timeout", bus.mem_timeout, 1'b1);
    chk("to_err_pc_en", bus.pc_en, 1'b0);
    chk("to_err_req", bus.dmem_req, 1'b0);
    chk("to_err_stall_cnt", bus.stall_cnt, 32'd9);
    cyc(); idle(); #1;
    chk("to_err2_timeout", bus.mem_timeout, 1'b1);
    chk("to_err2_pc_en", bus.pc_en, 1'b0);
    chk("to_err2_stall_cnt", bus.stall_cnt, 32'd10);
    rst = 1'b0; #1;
    chk("to_rst_timeout", bus.mem_timeout, 1'b0);
    chk("to_rst_stall_cnt", bus.stall_cnt, 32'd0);
    cyc(); rst = 1'b1; #1;
    chk("to_rel_pc_en", bus.pc_en, 1'b1);
    chk("to_rel_flush", bus.pipe_flush, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
